load_align_unit: RTL

- Parametrised, multi-cycle successor to the single-cycle load byte-extract logic.
- Accepts a load request (address, size, signedness) from the pipeline's memory stage and issues one or two word-aligned reads to data memory.
- Extracts the addressed byte, halfword, word or doubleword, then zero- or sign-extends it.
- Returns the result over a valid/ready handshake.
- Misaligned accesses that cross a word boundary are split into two memory reads and merged.

---
 rtl/load_align_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/load_align_unit.sv
// Multi-cycle load unit: issues one or two aligned reads,
// merges them, and extracts/extends the addressed field.
module load_align_unit #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {
        IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic              cross_q, cross_d;
    logic [DATA_W-1:0] word0_q, word0_d;
    logic              mreq_v_q, mreq_v_d;
    logic [ADDR_W-1:0] mreq_a_q, mreq_a_d;
    logic              rsp_v_q, rsp_v_d;
    logic [DATA_W-1:0] rsp_d_q, rsp_d_d;
    logic              rsp_e_q, rsp_e_d;

    logic [3:0]        req_sb;
    logic [OW-1:0]     req_off;
    logic [ADDR_W-1:0] req_base;
    logic [ADDR_W-1:0] base;
    logic              req_mis;
    logic              req_bad;
    logic              req_cross;

    logic [DATA_W-1:0]   asm_hi;
    logic [DATA_W-1:0]   asm_lo;
    logic [2*DATA_W-1:0] cat;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   mask;
    logic [DATA_W-1:0]   fill;
    logic                top;
    logic [DATA_W-1:0]   result;

    assign req_sb   = 4'd1 << req_size;
    assign req_off  = req_addr[OW-1:0];
    assign req_base = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
    assign base     = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    assign req_mis  = |({1'b0, req_addr[2:0]} & (req_sb - 4'd1));
    assign req_bad  = (DATA_W == 32 && req_size == 2'b11)
                   || (!ALLOW_MISALIGNED && req_mis);
    assign req_cross = ({{(5-OW){1'b0}}, req_off} + {1'b0, req_sb})
                     > 5'(NB);

    // Merge the fetched words, align the field to bit 0 and extend it
    always_comb begin
        asm_hi = '0;
        asm_lo = mem_rdata;
        if (state_q == WAIT1) begin
            asm_hi = mem_rdata;
            asm_lo = word0_q;
        end
        cat     = {asm_hi, asm_lo};
        shifted = DATA_W'(cat >> {addr_q[OW-1:0], 3'b000});
        mask    = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < (1 << size_q)) mask[i*8 +: 8] = 8'hFF;
        end
        case (size_q)
            2'b00:   top = shifted[7];
            2'b01:   top = shifted[15];
            2'b10:   top = shifted[31];
            default: top = shifted[DATA_W-1];
        endcase
        fill   = {DATA_W{sgn_q & top}};
        result = (shifted & mask) | (fill & ~mask);
    end

    // Next-state and registered-output computation for the load FSM
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        cross_d  = cross_q;
        word0_d  = word0_q;
        mreq_v_d = mreq_v_q;
        mreq_a_d = mreq_a_q;
        rsp_v_d  = rsp_v_q;
        rsp_d_d  = rsp_d_q;
        rsp_e_d  = rsp_e_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    cross_d = req_cross;
                    if (req_bad) begin
                        state_d = RESP;
                        rsp_v_d = 1'b1;
                        rsp_e_d = 1'b1;
                        rsp_d_d = '0;
                    end else begin
                        state_d  = REQ0;
                        mreq_v_d = 1'b1;
                        mreq_a_d = req_base;
                    end
                end
            end
            REQ0: begin
                if (mem_req_ready) begin
                    mreq_v_d = 1'b0;
                    state_d  = WAIT0;
                end
            end
            WAIT0: begin
                if (mem_rsp_valid) begin
                    word0_d = mem_rdata;
                    if (cross_q) begin
                        state_d  = REQ1;
                        mreq_v_d = 1'b1;
                        mreq_a_d = base + ADDR_W'(NB);
                    end else begin
                        state_d = RESP;
                        rsp_v_d = 1'b1;
                        rsp_e_d = 1'b0;
                        rsp_d_d = result;
                    end
                end
            end
            REQ1: begin
                if (mem_req_ready) begin
                    mreq_v_d = 1'b0;
                    state_d  = WAIT1;
                end
            end
            WAIT1: begin
                if (mem_rsp_valid) begin
                    state_d = RESP;
                    rsp_v_d = 1'b1;
                    rsp_e_d = 1'b0;
                    rsp_d_d = result;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_v_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers with async clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            sgn_q    <= 1'b0;
            cross_q  <= 1'b0;
            word0_q  <= '0;
            mreq_v_q <= 1'b0;
            mreq_a_q <= '0;
            rsp_v_q  <= 1'b0;
            rsp_d_q  <= '0;
            rsp_e_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            cross_q  <= cross_d;
            word0_q  <= word0_d;
            mreq_v_q <= mreq_v_d;
            mreq_a_q <= mreq_a_d;
            rsp_v_q  <= rsp_v_d;
            rsp_d_q  <= rsp_d_d;
            rsp_e_q  <= rsp_e_d;
        end
    end

    assign req_ready     = reset & (state_q == IDLE);
    assign mem_req_valid = mreq_v_q;
    assign mem_req_addr  = mreq_a_q;
    assign rsp_valid     = rsp_v_q;
    assign rsp_data      = rsp_d_q;
    assign rsp_err       = rsp_e_q;

endmodule
